// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ 16-bit producers into one FIFO write port, bursts of up to MAX_BURST words.
// Latency: one IDLE arbitration cycle, then combinational pass-through; fifo_full stalls the burst in place.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(MAX_BURST) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  fifo_wr_en,
    output logic [15:0]           fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_id
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] burst_cnt;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          gnt_vld;
    logic          xfer;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IW-1:0];
    endfunction

    // Scan downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(rr_ptr, i)]) pick_idx = wrap_add(rr_ptr, i);
        end
    end

    assign next_ptr = wrap_add(grant_idx, 1);
    assign gnt_vld  = (state == BURST) && !reset;
    assign xfer     = gnt_vld && req_valid[grant_idx] && !fifo_full;

    always_comb begin
        req_ready = '0;
        if (gnt_vld) req_ready[grant_idx] = !fifo_full;
    end

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = xfer ? req_data[16*grant_idx +: 16] : 16'h0000;
    assign grant_valid  = gnt_vld;
    assign grant_id     = gnt_vld ? grant_idx : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_idx <= pick_idx;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // A dropped valid releases the grant even while the FIFO is full.
                    if (!req_valid[grant_idx]) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (!fifo_full) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == CW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed the DUT, expected writes
// (cycle, grant id, word) go into a scoreboard that a negedge monitor drains.
module tb_fifo_wr_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_wr_en;
    logic [15:0]   fifo_wr_data;
    logic          fifo_full;
    logic          grant_valid;
    logic [1:0]    grant_id;

    fifo_wr_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] pq[N][$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          full_lo = -1;
    int          full_hi = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, want);
        end
    endtask

    function automatic logic [15:0] mk(input int p, input int n);
        return 16'hA000 | 16'(p << 8) | 16'(n);
    endfunction

    task automatic load(input int p, input int cnt);
        for (int j = 1; j <= cnt; j++) pq[p].push_back(mk(p, j));
    endtask

    task automatic expect_wr(input int c, input int p, input int n);
        exp_t e;
        e.cyc = c; e.id = p; e.data = mk(p, n);
        sb.push_back(e);
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {16'h0, fifo_wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_id", {30'h0, grant_id}, e.id);
                chk("wr_data", {16'h0, fifo_wr_data}, {16'h0, e.data});
                chk("wr_grant_valid", {31'h0, grant_valid}, 1);
            end
        end else if (fifo_wr_data != 16'h0) begin
            chk("idle_data_zero", {16'h0, fifo_wr_data}, 0);
        end
    end

    task automatic drive(input int k);
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pq[i].size() > 0;
            req_data[16*i +: 16] = (pq[i].size() > 0) ? pq[i][0] : 16'h0;
        end
        fifo_full = (k >= full_lo) && (k < full_hi);
    endtask

    // Entered just after a rising edge; runs n cycles of producer behaviour.
    task automatic run(input int n);
        logic [N-1:0] acc;
        for (int k = 0; k < n; k++) begin
            drive(k);
            @(negedge clk);
            acc = req_valid & req_ready;
            if (fifo_full) chk("stall_ready", {28'h0, req_ready}, 0);
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
        end
        chk("sb_drained", sb.size(), 0);
        full_lo = -1;
        full_hi = -1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("reset_outputs", {9'h0, req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id}, 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        reset     = 1'b1;
        req_valid = '1;
        req_data  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        fifo_full = 1'b0;

        // Outputs stay quiet under reset even with every producer requesting.
        do_reset(3);

        // Single requester, 6 words: bursts of 4 then 2 with an IDLE cycle between.
        load(1, 6);
        t0 = cyc;
        for (int j = 1; j <= 4; j++) expect_wr(t0 + j, 1, j);
        expect_wr(t0 + 6, 1, 5);
        expect_wr(t0 + 7, 1, 6);
        run(10);

        // Round robin after a fresh reset: order 0,1,2,3.
        req_valid = '0;
        do_reset(2);
        for (int p = 0; p < N; p++) load(p, 4);
        t0 = cyc;
        for (int p = 0; p < N; p++)
            for (int j = 1; j <= 4; j++) expect_wr(t0 + 5*p + j, p, j);
        run(22);

        // Backpressure: full for 3 cycles after the second word.
        load(0, 4);
        t0 = cyc;
        full_lo = 3;
        full_hi = 6;
        expect_wr(t0 + 1, 0, 1);
        expect_wr(t0 + 2, 0, 2);
        expect_wr(t0 + 6, 0, 3);
        expect_wr(t0 + 7, 0, 4);
        run(9);

        // Early release by producer 2 moves rr_ptr to 3: producer 3 before 0.
        load(2, 1);
        load(3, 2);
        load(0, 2);
        t0 = cyc;
        expect_wr(t0 + 1, 2, 1);
        expect_wr(t0 + 4, 3, 1);
        expect_wr(t0 + 5, 3, 2);
        expect_wr(t0 + 8, 0, 1);
        expect_wr(t0 + 9, 0, 2);
        run(12);

        // Wrap: producer 2 burst leaves rr_ptr=3, then only producer 0 remains.
        load(2, 1);
        load(0, 1);
        t0 = cyc;
        expect_wr(t0 + 1, 2, 1);
        expect_wr(t0 + 4, 0, 1);
        run(7);

        // Reset mid-burst after 2 words, then 4'b1100 must grant producer 2 first.
        load(1, 6);
        t0 = cyc;
        expect_wr(t0 + 1, 1, 1);
        expect_wr(t0 + 2, 1, 2);
        run(3);
        do_reset(2);
        pq[1].delete();
        load(2, 2);
        load(3, 1);
        t0 = cyc;
        expect_wr(t0 + 1, 2, 1);
        expect_wr(t0 + 2, 2, 2);
        expect_wr(t0 + 5, 3, 1);
        run(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
